// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eq_pkg
//  Description : Shared definitions for the equalizer band mixer: default
//                widths, FSM state type, unity-gain and address-width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package eq_pkg;

    localparam int DEF_N_BANDS   = 10;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_GAIN_W    = 24;
    localparam int DEF_GAIN_FRAC = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Fixed-point 1.0 for a gain with FRAC fractional bits.
    function automatic longint unity_gain(input int frac);
        return longint'(1) <<< frac;
    endfunction

    // Address width for an n-entry table; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eq_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : eq_round_sat
//  Description : Combinational round-half-up and saturate. Drops GAIN_FRAC
//                fractional bits from the accumulator and clamps the result
//                to a signed DATA_W range.
//  Ports       : acc      in   ACC_W   signed accumulator value
//                data_out out  DATA_W  rounded, clamped sample
//                sat      out  1       clamping happened
//  Revision    : 1.0  initial release
// ============================================================================
module eq_round_sat #(
    parameter int ACC_W     = 52,
    parameter int DATA_W    = 24,
    parameter int GAIN_FRAC = 20
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     sat
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(longint'(1) <<< (GAIN_FRAC - 1));
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shift;

    assign w_sum   = {acc[ACC_W-1], acc} + HALF;
    // Arithmetic shift floors, so +half then floor rounds ties toward +inf.
    assign w_shift = w_sum >>> GAIN_FRAC;

    always_comb begin
        sat      = 1'b0;
        data_out = w_shift[DATA_W-1:0];
        if (w_shift > MAX_V) begin
            sat      = 1'b1;
            data_out = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shift < MIN_V) begin
            sat      = 1'b1;
            data_out = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/eq_band_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : eq_band_mixer
//  Description : Weights N_BANDS band samples by per-band gains through one
//                time-multiplexed MAC, then rounds and saturates the sum.
//                Gains are double-buffered; the active bank only reloads in
//                IDLE so a sample is never mixed with a half-updated bank.
//  Ports       : clk, rst_n            clock, async active-low reset
//                bands_in/in_valid/in_ready     sample-set input handshake
//                gain_we/gain_addr/gain_wdata   shadow gain write
//                gain_commit                    shadow->active request
//                audio_out/out_valid/out_ready  mixed output handshake
//                sat_flag/sat_clr               sticky saturation flag
//  Revision    : 1.0  initial release
// ============================================================================
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter  int N_BANDS   = DEF_N_BANDS,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int GAIN_W    = DEF_GAIN_W,
    parameter  int GAIN_FRAC = DEF_GAIN_FRAC,
    localparam int AW        = addr_width(N_BANDS),
    localparam int ACC_W     = DATA_W + GAIN_W + $clog2(N_BANDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_BANDS*DATA_W-1:0]   bands_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        gain_we,
    input  logic [AW-1:0]               gain_addr,
    input  logic [GAIN_W-1:0]           gain_wdata,
    input  logic                        gain_commit,
    output logic [DATA_W-1:0]           audio_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat_flag,
    input  logic                        sat_clr
);

    localparam int PROD_W = DATA_W + GAIN_W;
    localparam logic signed [GAIN_W-1:0] UNITY     = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [AW-1:0]            LAST_IDX  = AW'(N_BANDS - 1);
    localparam logic [AW:0]              N_BANDS_V = (AW + 1)'(N_BANDS);

    state_t                     r_state;
    logic [N_BANDS*DATA_W-1:0]  r_bands;
    logic signed [GAIN_W-1:0]   r_shadow [N_BANDS];
    logic signed [GAIN_W-1:0]   r_active [N_BANDS];
    logic                       r_pending;
    logic signed [ACC_W-1:0]    r_acc;
    logic [AW-1:0]              r_idx;

    logic signed [DATA_W-1:0]   w_sample;
    logic signed [GAIN_W-1:0]   w_gain;
    logic signed [PROD_W-1:0]   w_sample_x;
    logic signed [PROD_W-1:0]   w_gain_x;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_x;
    logic signed [DATA_W-1:0]   w_rounded;
    logic                       w_sat;
    logic                       w_addr_ok;
    logic                       w_copy;

    assign w_sample   = r_bands[r_idx*DATA_W +: DATA_W];
    assign w_gain     = r_active[r_idx];
    assign w_sample_x = {{GAIN_W{w_sample[DATA_W-1]}}, w_sample};
    assign w_gain_x   = {{DATA_W{w_gain[GAIN_W-1]}}, w_gain};
    // Full-precision product; ACC_W has log2(N_BANDS) headroom bits on top.
    assign w_prod     = w_sample_x * w_gain_x;
    assign w_prod_x   = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    assign w_addr_ok  = ({1'b0, gain_addr} < N_BANDS_V);
    // Active bank only reloads while idle, so MAC/RND always see one bank.
    assign w_copy     = (r_state == IDLE) && r_pending;

    eq_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_round_sat (
        .acc      (r_acc),
        .data_out (w_rounded),
        .sat      (w_sat)
    );

    // Shadow bank: writable at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_BANDS; k++) r_shadow[k] <= UNITY;
        end else if (gain_we && w_addr_ok) begin
            r_shadow[gain_addr] <= gain_wdata;
        end
    end

    // Control FSM, active bank, MAC datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bands   <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            audio_out <= '0;
            sat_flag  <= 1'b0;
            for (int k = 0; k < N_BANDS; k++) r_active[k] <= UNITY;
        end else begin
            // A new request wins over the clear caused by a copy.
            r_pending <= gain_commit | (r_pending & ~w_copy);
            if (w_copy) begin
                for (int k = 0; k < N_BANDS; k++) r_active[k] <= r_shadow[k];
            end

            if ((r_state == RND) && w_sat) sat_flag <= 1'b1;
            else if (sat_clr)              sat_flag <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bands  <= bands_in;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_x;
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == LAST_IDX) r_state <= RND;
                end
                RND: begin
                    audio_out <= w_rounded;
                    out_valid <= 1'b1;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_band_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eq_band_mixer
//  Description : Scoreboard bench for eq_band_mixer. A driver issues sample
//                sets and gain updates; a reference model computes each
//                expected mix arithmetically and queues it; a monitor pops
//                and compares every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eq_band_mixer;

    localparam int N   = 10;
    localparam int DW  = 24;
    localparam int GW  = 24;
    localparam int GF  = 20;
    localparam int AW  = 4;
    localparam int LAT = N + 1;
    localparam int UNITY = 1 << GF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*DW-1:0]   bands_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              gain_we = 1'b0;
    logic [AW-1:0]     gain_addr = '0;
    logic [GW-1:0]     gain_wdata = '0;
    logic              gain_commit = 1'b0;
    logic [DW-1:0]     audio_out;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              sat_flag;
    logic              sat_clr = 1'b0;

    always #5 clk = ~clk;

    eq_band_mixer #(
        .N_BANDS   (N),
        .DATA_W    (DW),
        .GAIN_W    (GW),
        .GAIN_FRAC (GF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bands_in    (bands_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gain_we     (gain_we),
        .gain_addr   (gain_addr),
        .gain_wdata  (gain_wdata),
        .gain_commit (gain_commit),
        .audio_out   (audio_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr)
    );

    typedef struct {
        logic [DW-1:0] val;
        bit            clamp;
        longint        acc_cyc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    // Reference model state.
    int     shadow_m[N];
    int     active_m[N];
    int     snap_m[N];
    bit     pend_m = 1'b0;
    bit     sat_m = 1'b0;
    int     cur_b[N];

    int     stall_pct = 0;
    bit     hold_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 out_ready = hold_low ? 1'b0 : (int'($urandom_range(0, 99)) >= stall_pct);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            shadow_m[k] = UNITY;
            active_m[k] = UNITY;
            snap_m[k]   = UNITY;
        end
        pend_m = 1'b0;
        sat_m  = 1'b0;
    endtask

    // Weighted sum, round half toward +inf, clamp to the signed output range.
    function automatic exp_t model_mix();
        exp_t   e;
        longint s = 0;
        longint r;
        longint maxv = (longint'(1) <<< (DW - 1)) - 1;
        longint minv = -(longint'(1) <<< (DW - 1));
        for (int k = 0; k < N; k++) s += longint'(cur_b[k]) * longint'(active_m[k]);
        r = (s + (longint'(1) <<< (GF - 1))) >>> GF;
        e.clamp = 1'b0;
        if (r > maxv) begin r = maxv; e.clamp = 1'b1; end
        else if (r < minv) begin r = minv; e.clamp = 1'b1; end
        e.val = r[DW-1:0];
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic send(input bit with_commit);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < N; k++) bands_in[k*DW +: DW] = cur_b[k][DW-1:0];
        in_valid    = 1'b1;
        gain_commit = with_commit;
        // Earlier commits land before this capture; one issued now waits.
        if (pend_m) begin
            active_m = snap_m;
            pend_m   = 1'b0;
        end
        if (with_commit) begin
            snap_m = shadow_m;
            pend_m = 1'b1;
        end
        e = model_mix();
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic write_gain(input int addr, input int val, input bit we, input bit commit);
        @(posedge clk);
        #1;
        gain_we     = we;
        gain_addr   = addr[AW-1:0];
        gain_wdata  = val[GW-1:0];
        gain_commit = commit;
        if (we && addr < N) shadow_m[addr] = val;
        if (commit) begin
            snap_m = shadow_m;
            pend_m = 1'b1;
        end
        @(posedge clk);
        #1;
        gain_we     = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_bands(input int v);
        for (int k = 0; k < N; k++) cur_b[k] = v;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            cur_b[k] = (int'($urandom_range(0, 16777215)) - 8388608) >>> $urandom_range(0, 20);
    endtask

    task automatic pulse_sat_clr();
        @(posedge clk);
        #1 sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        sat_m = 1'b0;
        @(negedge clk);
        check("sat_clr", sat_flag, 0);
    endtask

    // Monitor: handshake checks and scoreboard comparison.
    initial begin : monitor
        bit            prev_ov = 1'b0;
        bit            prev_or = 1'b0;
        logic [DW-1:0] prev_data = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                prev_or = 1'b0;
            end else begin
                if (prev_ov && !prev_or) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", audio_out, prev_data);
                end
                if (out_valid) check("in_ready_busy", in_ready, 0);
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("unexpected_out", 0, 1);
                    else check("latency", cyc - sb[0].acc_cyc, LAT);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("audio_out", audio_out, e.val);
                    if (e.clamp) sat_m = 1'b1;
                    check("sat_flag", sat_flag, sat_m);
                end
                prev_ov   = out_valid;
                prev_or   = out_ready;
                prev_data = audio_out;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_audio_out", audio_out, 0);
        check("rst_sat_flag", sat_flag, 0);

        // Unity gains: 10 x 256.
        fill_bands(256);
        send(0);
        wait_drain();

        // Shadow write alone does not affect the mix; out-of-range address ignored.
        write_gain(3, 0, 1, 0);
        write_gain(12, 12345, 1, 0);
        fill_bands(256);
        send(0);
        wait_drain();
        write_gain(0, 0, 0, 1);
        fill_bands(256);
        send(0);
        wait_drain();

        // Saturation both ways, clear, and clear colliding with a new clamp.
        fill_bands(32'h007F_FFFF);
        send(0);
        wait_drain();
        fill_bands(-8388608);
        send(0);
        wait_drain();
        pulse_sat_clr();
        fill_bands(32'h007F_FFFF);
        send(0);
        repeat (10) @(posedge clk);
        #1 sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        wait_drain();

        // Rounding with gain0 = 0.5 and all other gains zero.
        for (int k = 1; k < N; k++) write_gain(k, 0, 1, 0);
        write_gain(0, 32'h0008_0000, 1, 1);
        fill_random(); cur_b[0] = 1;  send(0);
        fill_random(); cur_b[0] = -1; send(0);
        fill_random(); cur_b[0] = 3;  send(0);
        wait_drain();

        // Output stall with a combined write+commit during the hold.
        hold_low = 1'b1;
        fill_random();
        send(0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", out_valid, 1);
        repeat (5) @(posedge clk);
        write_gain(1, 32'h0010_0000, 1, 1);
        repeat (14) @(posedge clk);
        hold_low = 1'b0;
        fill_random();
        send(0);
        wait_drain();

        // Commit coinciding with capture applies only to the following sample.
        write_gain(2, 32'h0020_0000, 1, 0);
        fill_random();
        send(1);
        fill_random();
        send(0);
        wait_drain();

        // Randomized traffic with stalls and gain updates.
        stall_pct = 30;
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_gain(int'($urandom_range(0, N - 1)),
                           int'($urandom_range(0, 4194303)) - 2097152, 1, 0);
            if ($urandom_range(0, 1) == 1) write_gain(0, 0, 0, 1);
            fill_random();
            send(0);
        end
        wait_drain();
        stall_pct = 0;

        // Reset mid-MAC discards the sample and restores unity gains.
        fill_bands(256);
        send(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        model_reset();
        #2;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_sat_flag", sat_flag, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill_bands(256);
        send(0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
